ram40_port_ctrl: RTL

RAM40_PORT_CTRL -- requirements
Module: ram40_port_ctrl

---
 rtl/ram40_port_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ram40_port_ctrl.sv
// ram40_port_ctrl
//   Bridges a 32-bit word request channel onto one 256x16 block RAM.
//   Every word occupies two consecutive halfword locations, so each access
//   takes two RAM cycles. A write needs 3 cycles and a read needs 4 cycles,
//   counted from acceptance back to IDLE. After reset the controller can
//   zero-fill the whole RAM before it accepts any request.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we, req_addr[6:0]     write enable, word address
//   req_wdata[31:0], req_be   write data, byte enables
//   rsp_valid, rsp_rdata      one-cycle read strobe, read data (held)
//   busy                      clear sequence in progress
//   ram_re, ram_raddr         RAM read port (data returns one cycle later)
//   ram_rdata                 RAM registered read data
//   ram_we, ram_waddr,        RAM write port; ram_mask bit=1 leaves that
//   ram_wdata, ram_mask       bit unchanged
module ram40_port_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        ram_re,
  output logic [10:0] ram_raddr,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  output logic [10:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic [15:0] ram_mask
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_RD_END
  } state_t;

  // Halfword address of one half of word addr.
  function automatic logic [10:0] f_half_addr(input logic [6:0] addr, input logic hi);
    return {3'b000, addr, hi};
  endfunction

  // Two byte enables -> 16-bit write mask (1 = keep the bit).
  function automatic logic [15:0] f_mask(input logic [1:0] be);
    return {{8{~be[1]}}, {8{~be[0]}}};
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [6:0]  r_addr;
  logic [15:0] r_wdata_hi;
  logic [1:0]  r_be_hi;
  logic [15:0] r_lo;
  logic [31:0] r_rdata;
  logic        r_rsp_valid;
  logic        r_ready;
  logic        r_busy;
  logic        r_ram_we;
  logic        r_ram_re;
  logic [10:0] r_ram_waddr;
  logic [10:0] r_ram_raddr;
  logic [15:0] r_ram_wdata;
  logic [15:0] r_ram_mask;

  logic [7:0]  w_cnt_nxt;
  assign w_cnt_nxt = r_cnt + 8'd1;

  // All outputs are registered for the state being entered. The strobes are
  // additionally gated by rst, so they read 0 from the first reset cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_cnt       <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_ready     <= !CLEAR_ON_RESET;
      r_busy      <= CLEAR_ON_RESET;
      r_ram_we    <= CLEAR_ON_RESET;
      r_ram_re    <= 1'b0;
      r_ram_waddr <= 11'd0;
      r_ram_raddr <= 11'd0;
      r_ram_wdata <= 16'd0;
      r_ram_mask  <= CLEAR_ON_RESET ? 16'h0000 : 16'hFFFF;
    end else begin
      r_rsp_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_ram_waddr <= 11'd0;
      r_ram_raddr <= 11'd0;
      r_ram_wdata <= 16'd0;
      r_ram_mask  <= 16'hFFFF;

      case (r_state)
        S_CLEAR: begin
          if (r_cnt == 8'd255) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_busy      <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_waddr <= {3'b000, w_cnt_nxt};
            r_ram_mask  <= 16'h0000;
          end
        end

        S_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_wdata_hi <= req_wdata[31:16];
            r_be_hi    <= req_be[3:2];
            if (req_we) begin
              r_state     <= S_WR_LO;
              r_ram_we    <= |req_be[1:0];
              r_ram_waddr <= f_half_addr(req_addr, 1'b0);
              r_ram_wdata <= req_wdata[15:0];
              r_ram_mask  <= f_mask(req_be[1:0]);
            end else begin
              r_state     <= S_RD_LO;
              r_ram_re    <= 1'b1;
              r_ram_raddr <= f_half_addr(req_addr, 1'b0);
            end
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_WR_LO: begin
          r_state     <= S_WR_HI;
          r_ram_we    <= |r_be_hi;
          r_ram_waddr <= f_half_addr(r_addr, 1'b1);
          r_ram_wdata <= r_wdata_hi;
          r_ram_mask  <= f_mask(r_be_hi);
        end

        S_WR_HI: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end

        S_RD_LO: begin
          r_state     <= S_RD_HI;
          r_ram_re    <= 1'b1;
          r_ram_raddr <= f_half_addr(r_addr, 1'b1);
        end

        // RAM data lags ram_re by one cycle: low half arrives here.
        S_RD_HI: begin
          r_state <= S_RD_END;
          r_lo    <= ram_rdata;
        end

        S_RD_END: begin
          r_state     <= S_IDLE;
          r_rdata     <= {ram_rdata, r_lo};
          r_rsp_valid <= 1'b1;
          r_ready     <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready & ~rst;
  assign rsp_valid = r_rsp_valid & ~rst;
  assign ram_we    = r_ram_we & ~rst;
  assign ram_re    = r_ram_re & ~rst;
  assign rsp_rdata = r_rdata;
  assign busy      = r_busy;
  assign ram_waddr = r_ram_waddr;
  assign ram_raddr = r_ram_raddr;
  assign ram_wdata = r_ram_wdata;
  assign ram_mask  = r_ram_mask;

endmodule
